fifo_reader: RTL and testbench

Read-side drain engine for the circular FIFO. It pops bytes with `rd_en` and absorbs the FIFO's one-cycle `buf_out` read latency in a 3-entry output queue. It presents the bytes on a valid/ready byte stream toward downstream consumers. Draining is burst-gated: it starts once the FIFO holds at least a programmable threshold, or on `flush`, and it runs until the FIFO is empty.

---
 rtl/fifo_reader.sv | 82 ++++++++
 tb/tb_fifo_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - burst-gated FIFO drain engine with a 3-entry output queue
// Absorbs the FIFO's one-cycle read latency and presents bytes on a valid/ready stream.
module fifo_reader #(
  parameter int BUF_WIDTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           buf_out,
  input  logic                 buf_empty,
  input  logic [BUF_WIDTH:0]   fifo_counter,
  output logic                 rd_en,
  input  logic [BUF_WIDTH:0]   burst_thr,
  input  logic                 flush,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CNT_W-1:0]     rd_count,
  output logic                 busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]           state;
  logic [7:0]           q [0:2];
  logic [1:0]           head;
  logic [1:0]           tail;
  logic [1:0]           occ;
  logic                 inflight;
  logic [BUF_WIDTH:0]   thr_eff;
  logic                 push;
  logic                 pop;

  assign thr_eff = (burst_thr == '0) ? {{BUF_WIDTH{1'b0}}, 1'b1} : burst_thr;
  assign push    = inflight;
  assign pop     = m_valid && m_ready;

  // Issue only while the queue can absorb every byte already requested; m_ready is not involved.
  assign rd_en   = (state == DRAIN) && !buf_empty &&
                   (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);
  assign m_valid = (occ != 2'd0);
  assign m_data  = q[head];
  assign busy    = (state == DRAIN) || m_valid || inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      head     <= 2'd0;
      tail     <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      rd_count <= '0;
      for (int i = 0; i < 3; i++) q[i] <= 8'h00;
    end else begin
      case (state)
        IDLE:    if (!buf_empty && (fifo_counter >= thr_eff || flush)) state <= DRAIN;
        DRAIN:   if (buf_empty) state <= IDLE;
        default: state <= IDLE;
      endcase

      inflight <= rd_en;

      if (push) begin
        q[tail] <= buf_out;
        tail    <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
      end

      if (pop) begin
        head     <= (head == 2'd2) ? 2'd0 : head + 2'd1;
        rd_count <= rd_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb/tb_fifo_reader.sv - directed bench for fifo_reader against a behavioural 8-deep FIFO
module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  buf_out;
  logic        buf_empty;
  logic [3:0]  fifo_counter;
  logic        rd_en;
  logic [3:0]  burst_thr;
  logic        flush;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  rd_count;
  logic        busy;

  logic        wr;
  logic [7:0]  wdata;
  logic [7:0]  fmem [0:7];
  logic [2:0]  wp = 3'd0;
  logic [2:0]  rp = 3'd0;
  logic [3:0]  fcnt = 4'd0;

  int          vectors = 0;
  int          miscompares = 0;
  int          pops = 0;
  int          cyc = 0;
  int          p0;
  int          n;
  logic [7:0]  got [$];
  int          got_cyc [$];

  always #5 clk = ~clk;

  fifo_reader #(.BUF_WIDTH(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .buf_out(buf_out), .buf_empty(buf_empty),
    .fifo_counter(fifo_counter), .rd_en(rd_en), .burst_thr(burst_thr),
    .flush(flush), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rd_count(rd_count), .busy(busy)
  );

  // Circular FIFO model: registered occupancy, read data one cycle after rd_en.
  assign buf_empty    = (fcnt == 4'd0);
  assign fifo_counter = fcnt;

  always @(posedge clk) begin
    cyc++;
    if (rd_en) pops++;
    if (wr && fcnt != 4'd8) begin
      fmem[wp] <= wdata;
      wp <= wp + 3'd1;
    end
    if (rd_en) begin
      buf_out <= fmem[rp];
      rp <= rp + 3'd1;
    end
    fcnt <= fcnt + {3'b000, (wr && fcnt != 4'd8)} - {3'b000, rd_en};
  end

  always @(negedge clk) begin
    if (m_valid && m_ready && !rst) begin
      got.push_back(m_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wdata = b;
    wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; wdata = 8'h00; burst_thr = 4'd4; flush = 1'b0; m_ready = 1'b1;
    tick(2);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_rd_count", rd_count, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick();

    // threshold start
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    tick(6);
    chk("thr_below_pops", pops, 0);
    chk("thr_below_busy", busy, 0);
    write_byte(8'h44);
    tick(12);
    chk("thr_pops", pops, 4);
    chk("thr_len", got.size(), 4);
    chk("thr_b0", got[0], 8'h11);
    chk("thr_b1", got[1], 8'h22);
    chk("thr_b2", got[2], 8'h33);
    chk("thr_b3", got[3], 8'h44);
    chk("thr_rd_count", rd_count, 4);
    chk("thr_busy", busy, 0);

    // flush
    got.delete(); got_cyc.delete();
    burst_thr = 4'd8;
    write_byte(8'hA5); write_byte(8'h5A);
    tick(6);
    chk("flush_wait_pops", pops, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(10);
    chk("flush_len", got.size(), 2);
    chk("flush_b0", got[0], 8'hA5);
    chk("flush_b1", got[1], 8'h5A);
    chk("flush_rd_count", rd_count, 6);
    chk("flush_fifo_empty", fcnt, 0);
    chk("flush_busy", busy, 0);

    // backpressure
    got.delete(); got_cyc.delete();
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 8; i++) write_byte(8'(i));
    tick(10);
    chk("bp_pops", pops - p0, 3);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_m_data", m_data, 0);
    chk("bp_fifo_left", fcnt, 5);
    tick(4);
    chk("bp_m_data_stable", m_data, 0);
    chk("bp_pops_stable", pops - p0, 3);
    m_ready = 1'b1;
    tick(20);
    chk("bp_len", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_b%0d", i), got[i], 32'(i));
      chk($sformatf("bp_cyc%0d", i), got_cyc[i] - got_cyc[0], 32'(i));
    end
    chk("bp_rd_count", rd_count, 14);
    chk("bp_busy", busy, 0);

    // threshold zero: m_valid three cycles after fifo_counter shows the byte
    got.delete(); got_cyc.delete();
    burst_thr = 4'd0;
    write_byte(8'h7E);
    chk("tz_counter", fcnt, 1);
    tick(2);
    chk("tz_valid_c2", m_valid, 0);
    tick();
    chk("tz_valid_c3", m_valid, 1);
    chk("tz_data", m_data, 8'h7E);
    tick(6);
    chk("tz_len", got.size(), 1);
    chk("tz_rd_count", rd_count, 15);

    // reset mid-burst with inflight=1 and occ=2
    got.delete(); got_cyc.delete();
    burst_thr = 4'd8;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) write_byte(8'h10 + 8'(i));
    n = 0;
    while (!(dut.inflight && dut.occ == 2'd2) && n < 30) begin
      tick();
      n++;
    end
    chk("rst_reach", (n < 30), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_busy", busy, 0);
    tick(2);
    rst = 1'b0;
    m_ready = 1'b1;
    tick(4);
    chk("rst_no_stale", got.size(), 0);
    chk("rst_idle_busy", busy, 0);
    chk("rst_fifo_left", fcnt, 5);
    burst_thr = 4'd5;
    tick(15);
    chk("rst_len", got.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_b%0d", i), got[i], 32'h13 + 32'(i));
    chk("rst_rd_count_after", rd_count, 5);

    // rd_count wrap with CNT_W=4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got.delete(); got_cyc.delete();
    burst_thr = 4'd1;
    for (int i = 0; i < 17; i++) write_byte(8'h20 + 8'(i));
    tick(12);
    chk("wrap_len", got.size(), 17);
    chk("wrap_first", got[0], 8'h20);
    chk("wrap_last", got[16], 8'h30);
    chk("wrap_rd_count", rd_count, 1);
    chk("wrap_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
